// File: rtl/ha_pkg.sv
// Shared definitions for the half-adder based serial adder slice.
package ha_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding; 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ha.sv
// Half adder: the team's basic datapath cell.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry of two single bits.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/ha_fa_cell.sv
// Full-add cell built from two half adders and an OR gate.
module ha_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    ha u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    ha u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    // At most one of the two half-adder carries can be set, so OR merges them.
    always_comb begin
        cout = c0 | c1;
    end

endmodule

// File: rtl/ha_serial_adder.sv
// Bit-serial adder controller: walks LSB-first through one shared full-add
// cell, one operand bit per clock, and pulses done with the registered result.
module ha_serial_adder
    import ha_pkg::*;
#(
    parameter int   WIDTH = DEFAULT_WIDTH,
    localparam int  CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             shift_en;
    logic             last_bit;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_bit;
    logic             fa_carry;

    ha_fa_cell u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_bit),
        .cout (fa_carry)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus load/shift strobes for the datapath.
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // start is ignored while bits are in flight.
                shift_en = 1'b1;
                if (last_bit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand/sum shift registers, carry, bit counter and registered flags.
    // NOTE: all datapath registers are reset (they are a handful of flops, not
    // a memory), so an aborted add leaves no stale operands or result behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next == ST_SHIFT);
            done <= (state_next == ST_DONE);
            if (load) begin
                op_a  <= a;
                op_b  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (shift_en) begin
                sum   <= {fa_bit, sum[WIDTH-1:1]};
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                carry <= fa_carry;
                cnt   <= cnt + 1'b1;
                // The carry out of the final bit becomes the result carry.
                if (last_bit) begin
                    cout <= fa_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_ha_serial_adder.sv
// Scoreboard bench for ha_serial_adder: stimulus pushes (A+B+cin) results
// with their due cycle; a monitor pops and compares on each done pulse.
module tb_ha_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               due;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    ha_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value k is seen between edge k and edge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain (WIDTH+1)-bit arithmetic.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input int due);
        exp_t        e;
        logic [WIDTH:0] t;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.due  = due;
        return e;
    endfunction

    // Pulse start for one edge from IDLE/DONE; returns at the negedge after
    // the accepting edge and queues the expected result.
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        int k;
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = ci;
        @(posedge clk);
        #1 k = cyc;
        sb.push_back(model(x, y, ci, k + WIDTH));
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
    endtask

    // Run to just after the done edge of an add issued via issue().
    task automatic finish_add();
        repeat (WIDTH) @(posedge clk);
    endtask

    // Monitor: checks results, their timing, busy length and flag exclusion.
    initial begin : monitor
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (busy && done) check("busy_done_exclusive", 1, 0);
                if (busy) begin
                    run++;
                end else if (run != 0) begin
                    check("busy_length", run, WIDTH);
                    run = 0;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", sum, e.sum);
                        check("cout", cout, e.cout);
                        check("done_cycle", cyc, e.due);
                    end
                end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    check("done_missing", 0, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {busy, done, cout, sum}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no start: outputs stay at zero.
        repeat (20) begin
            @(negedge clk);
            check("idle_outputs", {busy, done, cout, sum}, 0);
        end

        // Directed adds, including ripple and overflow.
        issue(8'h3C, 8'h0F, 1'b0); finish_add();
        issue(8'hFF, 8'h01, 1'b0); finish_add();
        issue(8'hA5, 8'h5A, 1'b1); finish_add();
        repeat (2) @(posedge clk);

        // start pulsed mid-add is ignored.
        issue(8'h37, 8'h44, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH - 3) @(posedge clk);
        repeat (3) @(posedge clk);

        // start held high: second operand set accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(posedge clk);
        #1 k = cyc;
        sb.push_back(model(8'h01, 8'h02, 1'b0, k + WIDTH));
        sb.push_back(model(8'h80, 8'h80, 1'b0, k + 2 * WIDTH + 1));
        @(negedge clk);
        a = 8'h80; b = 8'h80;
        repeat (WIDTH + 1) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(posedge clk);

        // Reset mid-operation discards the add.
        issue(8'h5A, 8'h33, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1 check("async_reset_outputs", {busy, done, cout, sum}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("held_reset_outputs", {busy, done, cout, sum}, 0);
        rst = 1'b0;
        repeat (WIDTH + 2) @(negedge clk) check("no_done_after_abort", done, 0);
        issue(8'h10, 8'h01, 1'b0); finish_add();

        // Random adds with random gaps (gap 0 means back-to-back).
        repeat (40) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            finish_add();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
